// File: rtl/operator_slot_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | operator_slot_sequencer: steps op_num through every operator slot once    |
// | per sample request, tagging each slot with its rhythm-mode operator type. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+

package operator_slot_sequencer_pkg;
  localparam int OP_TYPE_WIDTH = 3;

  typedef enum logic [OP_TYPE_WIDTH-1:0] {
    OP_NORMAL     = 3'd0,
    OP_BASS_DRUM  = 3'd1,
    OP_HI_HAT     = 3'd2,
    OP_TOM_TOM    = 3'd3,
    OP_SNARE_DRUM = 3'd4,
    OP_TOP_CYMBAL = 3'd5
  } operator_t;
endpackage

module operator_slot_sequencer
  import operator_slot_sequencer_pkg::*;
#(
  parameter int NUM_OPS     = 18,
  parameter int SLOT_CYCLES = 2,
  localparam int OP_NUM_WIDTH = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_clk_en,
  input  logic                         ryt,
  input  logic                         overrun_clr,
  output logic [OP_NUM_WIDTH-1:0]      op_num,
  output logic                         slot_en,
  output logic [$bits(operator_t)-1:0] op_type,
  output logic                         busy,
  output logic                         sweep_done,
  output logic                         overrun
);

  localparam int CNT_WIDTH = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0]    CNT_LAST = CNT_WIDTH'(SLOT_CYCLES - 1);
  localparam logic [OP_NUM_WIDTH-1:0] OP_LAST  = OP_NUM_WIDTH'(NUM_OPS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [OP_NUM_WIDTH-1:0] op_num_q, op_num_d;
  logic                    ryt_l_q, ryt_l_d;
  logic                    slot_en_q, slot_en_d;
  operator_t               op_type_q, op_type_d;
  logic                    busy_q, busy_d;
  logic                    sweep_done_q, sweep_done_d;
  logic                    overrun_q, overrun_d;

  logic w_start;
  logic w_cnt_wrap;
  logic w_last_cycle;

  // Rhythm mode repurposes operators 12..17 as the percussion voices.
  function automatic operator_t slot_type(input logic [OP_NUM_WIDTH-1:0] op,
                                          input logic rhythm);
    operator_t t;
    t = OP_NORMAL;
    if (rhythm) begin
      case (int'(op))
        12, 15:  t = OP_BASS_DRUM;
        13:      t = OP_HI_HAT;
        14:      t = OP_TOM_TOM;
        16:      t = OP_SNARE_DRUM;
        17:      t = OP_TOP_CYMBAL;
        default: t = OP_NORMAL;
      endcase
    end
    return t;
  endfunction

  assign w_start      = (state_q == S_IDLE) && sample_clk_en;
  assign w_cnt_wrap   = (cnt_q == CNT_LAST);
  assign w_last_cycle = (state_q == S_RUN) && w_cnt_wrap && (op_num_q == OP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sample_clk_en) state_d = S_RUN;
      S_RUN:   if (w_last_cycle)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is computed one cycle ahead so the flops present it aligned
  // with the slot it describes.
  always_comb begin
    cnt_d        = '0;
    op_num_d     = '0;
    ryt_l_d      = ryt_l_q;
    busy_d       = 1'b0;
    slot_en_d    = 1'b0;
    sweep_done_d = 1'b0;
    op_type_d    = OP_NORMAL;

    if (w_start) begin
      ryt_l_d = ryt;
    end else if ((state_q == S_RUN) && !w_last_cycle) begin
      if (w_cnt_wrap) begin
        op_num_d = op_num_q + OP_NUM_WIDTH'(1);
      end else begin
        cnt_d    = cnt_q + CNT_WIDTH'(1);
        op_num_d = op_num_q;
      end
    end

    if (state_d == S_RUN) begin
      busy_d       = 1'b1;
      slot_en_d    = (cnt_d == '0);
      sweep_done_d = (cnt_d == CNT_LAST) && (op_num_d == OP_LAST);
      op_type_d    = slot_type(op_num_d, ryt_l_d);
    end

    // A late request is dropped but remembered; setting wins over clearing.
    overrun_d = ((state_q == S_RUN) && sample_clk_en) || (overrun_q && !overrun_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      op_num_q     <= '0;
      ryt_l_q      <= 1'b0;
      slot_en_q    <= 1'b0;
      op_type_q    <= OP_NORMAL;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      op_num_q     <= op_num_d;
      ryt_l_q      <= ryt_l_d;
      slot_en_q    <= slot_en_d;
      op_type_q    <= op_type_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign op_num     = op_num_q;
  assign slot_en    = slot_en_q;
  assign op_type    = op_type_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;
  assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_operator_slot_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_operator_slot_sequencer: directed checks of sweep timing, rhythm types,|
// | overrun handling and reset for two slot lengths.                          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+

module tb_operator_slot_sequencer;
  import operator_slot_sequencer_pkg::*;

  logic       clk;
  logic       reset;
  logic       sample_clk_en;
  logic       ryt;
  logic       overrun_clr;
  logic [4:0] op_num;
  logic       slot_en;
  logic [2:0] op_type;
  logic       busy;
  logic       sweep_done;
  logic       overrun;

  logic       s1_sample_clk_en;
  logic       s1_ryt;
  logic       s1_overrun_clr;
  logic [4:0] s1_op_num;
  logic       s1_slot_en;
  logic [2:0] s1_op_type;
  logic       s1_busy;
  logic       s1_sweep_done;
  logic       s1_overrun;

  int errors = 0;
  int checks = 0;

  operator_slot_sequencer #(.NUM_OPS(18), .SLOT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .sample_clk_en(sample_clk_en), .ryt(ryt),
    .overrun_clr(overrun_clr), .op_num(op_num), .slot_en(slot_en),
    .op_type(op_type), .busy(busy), .sweep_done(sweep_done), .overrun(overrun)
  );

  operator_slot_sequencer #(.NUM_OPS(18), .SLOT_CYCLES(1)) dut_s1 (
    .clk(clk), .reset(reset), .sample_clk_en(s1_sample_clk_en), .ryt(s1_ryt),
    .overrun_clr(s1_overrun_clr), .op_num(s1_op_num), .slot_en(s1_slot_en),
    .op_type(s1_op_type), .busy(s1_busy), .sweep_done(s1_sweep_done),
    .overrun(s1_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] exp_type(input int op, input logic rhythm);
    if (!rhythm) return OP_NORMAL;
    case (op)
      12, 15:  return OP_BASS_DRUM;
      13:      return OP_HI_HAT;
      14:      return OP_TOM_TOM;
      16:      return OP_SNARE_DRUM;
      17:      return OP_TOP_CYMBAL;
      default: return OP_NORMAL;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after a rising edge, called cycle 0.
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if ({op_num, slot_en, op_type, busy, sweep_done, overrun} !== 12'd0) begin
      errors++;
      $display("FAIL reset.outputs got op=%0d slot=%0b type=%0d busy=%0b done=%0b ovr=%0b exp all 0",
               op_num, slot_en, op_type, busy, sweep_done, overrun);
    end
    checks++;
    if ({s1_op_num, s1_slot_en, s1_op_type, s1_busy, s1_sweep_done, s1_overrun} !== 12'd0) begin
      errors++;
      $display("FAIL reset.s1_outputs got op=%0d slot=%0b busy=%0b exp all 0",
               s1_op_num, s1_slot_en, s1_busy);
    end
    step();
    reset = 1'b0;
  endtask

  // rhythm_at_start selects the pulse-time ryt; ryt is flipped at cycle 20.
  task automatic test_sweep(input logic rhythm_at_start);
    logic       e_slot, e_busy, e_done;
    int         e_op;
    logic [2:0] e_type;
    do_reset();
    ryt = rhythm_at_start;
    repeat (10) step();
    sample_clk_en = 1'b1;
    step();
    sample_clk_en = 1'b0;
    for (int c = 11; c <= 47; c++) begin
      if (c == 20) ryt = ~rhythm_at_start;
      e_busy = (c <= 46);
      e_slot = (c <= 45) && (((c - 11) % 2) == 0);
      e_done = (c == 46);
      e_op   = e_busy ? (c - 11) / 2 : 0;
      e_type = e_busy ? exp_type(e_op, rhythm_at_start) : 3'(OP_NORMAL);
      checks++;
      if ({slot_en, busy, sweep_done} !== {e_slot, e_busy, e_done}) begin
        errors++;
        $display("FAIL sweep%0b.ctrl cyc=%0d got slot/busy/done=%b%b%b exp=%b%b%b",
                 rhythm_at_start, c, slot_en, busy, sweep_done, e_slot, e_busy, e_done);
      end
      checks++;
      if (op_num !== 5'(e_op)) begin
        errors++;
        $display("FAIL sweep%0b.op_num cyc=%0d got=%0d exp=%0d", rhythm_at_start, c, op_num, e_op);
      end
      checks++;
      if (op_type !== e_type) begin
        errors++;
        $display("FAIL sweep%0b.op_type cyc=%0d got=%0d exp=%0d", rhythm_at_start, c, op_type, e_type);
      end
      step();
    end
    ryt = 1'b0;
  endtask

  task automatic test_overrun();
    logic e_slot, e_busy, e_done, e_ovr;
    int   e_op;
    do_reset();
    repeat (10) step();
    sample_clk_en = 1'b1;
    step();
    sample_clk_en = 1'b0;
    for (int c = 11; c <= 47; c++) begin
      e_busy = (c <= 46);
      e_slot = (c <= 45) && (((c - 11) % 2) == 0);
      e_done = (c == 46);
      e_op   = e_busy ? (c - 11) / 2 : 0;
      e_ovr  = ((c >= 31) && (c <= 43)) || (c == 47);
      checks++;
      if ({slot_en, busy, sweep_done} !== {e_slot, e_busy, e_done} || op_num !== 5'(e_op)) begin
        errors++;
        $display("FAIL overrun.sweep cyc=%0d got slot/busy/done=%b%b%b op=%0d exp=%b%b%b op=%0d",
                 c, slot_en, busy, sweep_done, op_num, e_slot, e_busy, e_done, e_op);
      end
      checks++;
      if (overrun !== e_ovr) begin
        errors++;
        $display("FAIL overrun.flag cyc=%0d got=%0b exp=%0b", c, overrun, e_ovr);
      end
      sample_clk_en = (c == 30) || (c == 40) || (c == 46);
      overrun_clr   = (c == 40) || (c == 43);
      step();
    end
    sample_clk_en = 1'b0;
    overrun_clr   = 1'b1;
    checks++;
    if ({busy, overrun} !== 2'b01) begin
      errors++;
      $display("FAIL overrun.after_done got busy=%0b ovr=%0b exp busy=0 ovr=1", busy, overrun);
    end
    step();
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun.clear got=%0b exp=0", overrun);
    end
  endtask

  task automatic test_reset_mid_sweep();
    do_reset();
    ryt = 1'b1;
    repeat (10) step();
    sample_clk_en = 1'b1;
    step();
    sample_clk_en = 1'b0;
    ryt = 1'b0;
    repeat (14) step();
    reset = 1'b1;
    #1;
    checks++;
    if ({op_num, slot_en, op_type, busy, sweep_done, overrun} !== 12'd0) begin
      errors++;
      $display("FAIL midreset.async got op=%0d slot=%0b type=%0d busy=%0b done=%0b exp all 0",
               op_num, slot_en, op_type, busy, sweep_done);
    end
    step();
    reset = 1'b0;
    for (int c = 26; c <= 40; c++) begin
      checks++;
      if ({slot_en, busy, sweep_done} !== 3'b000) begin
        errors++;
        $display("FAIL midreset.idle cyc=%0d got slot/busy/done=%b%b%b exp=000",
                 c, slot_en, busy, sweep_done);
      end
      if (c == 40) sample_clk_en = 1'b1;
      step();
    end
    sample_clk_en = 1'b0;
    checks++;
    if ({slot_en, busy, op_num, op_type} !== {1'b1, 1'b1, 5'd0, 3'(OP_NORMAL)}) begin
      errors++;
      $display("FAIL midreset.restart got slot=%0b busy=%0b op=%0d type=%0d exp slot=1 busy=1 op=0 type=0",
               slot_en, busy, op_num, op_type);
    end
    step();
    step();
    checks++;
    if ({slot_en, op_num} !== {1'b1, 5'd1}) begin
      errors++;
      $display("FAIL midreset.second_slot got slot=%0b op=%0d exp slot=1 op=1", slot_en, op_num);
    end
  endtask

  task automatic test_back_to_back();
    logic e_slot, e_busy, e_done;
    int   e_op;
    do_reset();
    s1_sample_clk_en = 1'b1;
    step();
    s1_sample_clk_en = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      e_busy = (c <= 18) || (c >= 20);
      e_slot = e_busy;
      e_done = (c == 18);
      e_op   = (c <= 18) ? c - 1 : (c == 21 ? 1 : 0);
      checks++;
      if ({s1_slot_en, s1_busy, s1_sweep_done} !== {e_slot, e_busy, e_done}) begin
        errors++;
        $display("FAIL b2b.ctrl cyc=%0d got slot/busy/done=%b%b%b exp=%b%b%b",
                 c, s1_slot_en, s1_busy, s1_sweep_done, e_slot, e_busy, e_done);
      end
      checks++;
      if (s1_op_num !== 5'(e_op)) begin
        errors++;
        $display("FAIL b2b.op_num cyc=%0d got=%0d exp=%0d", c, s1_op_num, e_op);
      end
      checks++;
      if (s1_overrun !== 1'b0) begin
        errors++;
        $display("FAIL b2b.overrun cyc=%0d got=%0b exp=0", c, s1_overrun);
      end
      s1_sample_clk_en = (c == 19);
      step();
    end
    s1_sample_clk_en = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    sample_clk_en    = 1'b0;
    ryt              = 1'b0;
    overrun_clr      = 1'b0;
    s1_sample_clk_en = 1'b0;
    s1_ryt           = 1'b0;
    s1_overrun_clr   = 1'b0;
    #2;
    test_reset();
    test_sweep(1'b0);
    test_sweep(1'b1);
    test_overrun();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
